// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter for a single-port memory with fixed read latency
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReq0,
  input  logic              iReq1,
  input  logic              iWe0,
  input  logic              iWe1,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWData0,
  input  logic [DATA_W-1:0] iWData1,
  output logic              oGnt0,
  output logic              oGnt1,
  output logic              oRValid0,
  output logic              oRValid1,
  output logic [DATA_W-1:0] oRData,
  output logic              oMemEn,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oBusy,
  output logic              oOwner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic              r_owner;
  logic              r_we;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rv0;
  logic              r_rv1;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic              w_win;
  logic              w_pick;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_capture;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    w_next = r_state;
    w_win  = 1'b0;
    w_pick = r_owner;
    case (r_state)
      S_IDLE: begin
        if (iReq0 || iReq1) begin
          w_win  = 1'b1;
          w_pick = (iReq0 && iReq1) ? ~r_owner : iReq1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sel_we    = w_pick ? iWe1    : iWe0;
  assign w_sel_addr  = w_pick ? iAddr1  : iAddr0;
  assign w_sel_wdata = w_pick ? iWData1 : iWData0;
  assign w_capture   = (r_state == S_WAIT) && (r_cnt == 3'd1);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Outputs are registered off the next-state decision so they line up with the state they belong to.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_cnt       <= 3'd0;
      r_owner     <= 1'b1;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rv0       <= 1'b0;
      r_rv1       <= 1'b0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt0   <= w_win && !w_pick;
      r_gnt1   <= w_win && w_pick;
      r_mem_en <= w_win;
      r_mem_we <= w_win && w_sel_we;
      r_busy   <= (w_next != S_IDLE);
      r_rv0    <= w_capture && !r_owner;
      r_rv1    <= w_capture && r_owner;
      if (w_win) begin
        r_owner     <= w_pick;
        r_we        <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      if (r_state == S_ISSUE)
        r_cnt <= 3'(READ_LAT);
      else if (r_state == S_WAIT && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
      if (w_capture) r_rdata <= iMemRData;
    end
  end

  assign oGnt0     = r_gnt0;
  assign oGnt1     = r_gnt1;
  assign oRValid0  = r_rv0;
  assign oRValid1  = r_rv1;
  assign oRData    = r_rdata;
  assign oMemEn    = r_mem_en;
  assign oMemWe    = r_mem_we;
  assign oMemAddr  = r_mem_addr;
  assign oMemWData = r_mem_wdata;
  assign oBusy     = r_busy;
  assign oOwner    = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int RL = 2;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iReq0, iReq1, iWe0, iWe1;
  logic [31:0] iAddr0, iAddr1, iWData0, iWData1;
  logic        oGnt0, oGnt1, oRValid0, oRValid1;
  logic [31:0] oRData;
  logic        oMemEn, oMemWe;
  logic [31:0] oMemAddr, oMemWData;
  logic [31:0] iMemRData;
  logic        oBusy, oOwner;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iReq0(iReq0), .iReq1(iReq1), .iWe0(iWe0), .iWe1(iWe1),
    .iAddr0(iAddr0), .iAddr1(iAddr1), .iWData0(iWData0), .iWData1(iWData1),
    .oGnt0(oGnt0), .oGnt1(oGnt1), .oRValid0(oRValid0), .oRValid1(oRValid1),
    .oRData(oRData), .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .iMemRData(iMemRData), .oBusy(oBusy), .oOwner(oOwner)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_g[$];
  ev_t exp_r[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  wr_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1234_5678 : (a ^ 32'h5EED_0000);
  endfunction

  // Memory model: read data appears RL cycles after the enable cycle.
  logic [31:0] rd_pipe [RL];
  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    rd_pipe[0] <= (oMemEn && !oMemWe) ? rd_val(oMemAddr) : 32'h0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign iMemRData = rd_pipe[RL-1];

  always @(negedge iCLK) begin
    ev_t e;
    if (oMemEn && oMemWe) wr_cnt++;
    if (oGnt0 && oGnt1) check("gnt_both", 64'd1, 64'd0);
    if (oMemEn != (oGnt0 || oGnt1)) check("en_vs_gnt", 64'(oMemEn), 64'(oGnt0 || oGnt1));
    if (oGnt0 || oGnt1) begin
      if (exp_g.size() == 0) check("gnt_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_g.pop_front();
        check("gnt_port", 64'(oGnt1), 64'(e.port));
        check("gnt_cycle", 64'(cyc), 64'(e.cyc));
        check("mem_we", 64'(oMemWe), 64'(e.we));
        check("mem_addr", 64'(oMemAddr), 64'(e.addr));
        if (e.we) check("mem_wdata", 64'(oMemWData), 64'(e.data));
      end
    end
    if (oRValid0 && oRValid1) check("rv_both", 64'd1, 64'd0);
    if (oRValid0 || oRValid1) begin
      if (exp_r.size() == 0) check("rv_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_r.pop_front();
        check("rv_port", 64'(oRValid1), 64'(e.port));
        check("rv_cycle", 64'(cyc), 64'(e.cyc));
        check("rv_data", 64'(oRData), 64'(e.data));
        check("rv_owner", 64'(oOwner), 64'(e.port));
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge iCLK); #1; end
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin iReq0 = r; iWe0 = we; iAddr0 = a; iWData0 = d; end
    else        begin iReq1 = r; iWe1 = we; iAddr1 = a; iWData1 = d; end
  endtask

  // Single access from an idle arbiter; called one step after a rising edge.
  task automatic do_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    int c = cyc;
    exp_g.push_back('{port: p, we: we, addr: a, data: d, cyc: c + 1});
    if (!we) exp_r.push_back('{port: p, we: 1'b0, addr: a, data: rd_val(a), cyc: c + 2 + RL});
    drive(p, 1'b1, we, a, d);
    @(posedge iCLK); #1;
    drive(p, 1'b0, we, a, d);
    check("busy_after_win", 64'(oBusy), 64'd1);
    wait_until(we ? c + 2 : c + 3 + RL);
    check("busy_back_idle", 64'(oBusy), 64'd0);
    check("owner_after", 64'(oOwner), 64'(p));
  endtask

  // Both ports request reads continuously; grants must alternate starting at port 0.
  task automatic contend(input int n);
    int c = cyc;
    int p;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      p = k % 2;
      a = (p == 0) ? 32'h40 : 32'h44;
      exp_g.push_back('{port: p, we: 1'b0, addr: a, data: 32'h0, cyc: c + 1 + k * (RL + 3)});
      exp_r.push_back('{port: p, we: 1'b0, addr: a, data: rd_val(a), cyc: c + 2 + RL + k * (RL + 3)});
    end
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_until(c + 1 + (n - 1) * (RL + 3));
    iReq0 = 1'b0; iReq1 = 1'b0;
    wait_until(c + n * (RL + 3));
    check("contend_idle", 64'(oBusy), 64'd0);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_gnt"}, 64'({oGnt0, oGnt1, oRValid0, oRValid1}), 64'd0);
    check({tag, "_en"}, 64'({oMemEn, oMemWe}), 64'd0);
    check({tag, "_busy"}, 64'(oBusy), 64'd0);
    check({tag, "_owner"}, 64'(oOwner), 64'd1);
    check({tag, "_rdata"}, 64'(oRData), 64'd0);
  endtask

  initial begin
    int c, w0;
    iRST = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge iCLK);
    #1;
    reset_outputs("rst_init");
    check("rst_addr", 64'(oMemAddr), 64'd0);
    check("rst_wdata", 64'(oMemWData), 64'd0);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    check("idle_after_rst", 64'(oBusy), 64'd0);

    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    do_req(1, 1'b0, 32'h20, 32'h0);

    // Back-to-back writes: request stays high through the grant, new payload afterwards.
    c = cyc;
    w0 = wr_cnt;
    exp_g.push_back('{port: 0, we: 1'b1, addr: 32'h80, data: 32'hA5A5_A5A5, cyc: c + 1});
    exp_g.push_back('{port: 0, we: 1'b1, addr: 32'h84, data: 32'h5A5A_5A5A, cyc: c + 3});
    drive(0, 1'b1, 1'b1, 32'h80, 32'hA5A5_A5A5);
    @(posedge iCLK); #1;
    drive(0, 1'b1, 1'b1, 32'h84, 32'h5A5A_5A5A);
    wait_until(c + 3);
    iReq0 = 1'b0;
    @(negedge iCLK); #1;
    check("b2b_write_count", 64'(wr_cnt - w0), 64'd2);
    @(posedge iCLK); #1;

    do_req(0, 1'b0, 32'h30, 32'h0);

    iRST = 1'b0;
    #1;
    reset_outputs("rst_mid");
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    contend(4);

    // Reset during the latency window drops the response.
    c = cyc;
    exp_g.push_back('{port: 0, we: 1'b0, addr: 32'h50, data: 32'h0, cyc: c + 1});
    drive(0, 1'b1, 1'b0, 32'h50, 32'h0);
    @(posedge iCLK); #1;
    iReq0 = 1'b0;
    @(posedge iCLK); #1;
    check("in_wait_busy", 64'(oBusy), 64'd1);
    iRST = 1'b0;
    #1;
    reset_outputs("rst_wait");
    repeat (RL + 3) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    contend(2);

    repeat (3) @(posedge iCLK);
    #1;
    check("gnt_left", 64'(exp_g.size()), 64'd0);
    check("rv_left", 64'(exp_r.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
